// File: rtl/wrr_stream_arbiter_pkg.sv
// Shared definitions for the weighted round-robin stream arbiter.
// Latency: none (types and constant functions only).
// Backpressure: n/a.
package wrr_stream_arbiter_pkg;

    // Arbiter FSM: IDLE re-arbitrates, BURST keeps serving the current channel.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Ceiling log2 for parameter elaboration; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wrr_stream_arbiter_rr_pick.sv
// Rotating-priority encoder: first requester after LAST, wrapping around.
// Latency: combinational.
// Backpressure: none; the caller decides whether the pick is used.
// Ports:
//   REQ   [N_CH]        request vector
//   LAST  [clog2(N_CH)] previously served channel (lowest priority now)
//   VALID               any request present
//   IDX   [clog2(N_CH)] winning channel
module rr_pick
    import wrr_stream_arbiter_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]        REQ,
    input  logic [clog2(N_CH)-1:0] LAST,
    output logic                   VALID,
    output logic [clog2(N_CH)-1:0] IDX
);

    localparam int IW = clog2(N_CH);

    logic [2*N_CH-1:0] dbl;
    logic [2*N_CH-1:0] mask;
    logic [2*N_CH-1:0] hit;

    // Two copies of REQ side by side turn the wrap-around scan into a
    // linear one: positions LAST+1 .. LAST+N_CH cover every channel once.
    always_comb begin
        dbl  = {REQ, REQ};
        mask = '0;
        for (int j = 0; j < 2*N_CH; j++) begin
            mask[j] = (j > int'(LAST)) && (j <= int'(LAST) + N_CH);
        end
        hit   = dbl & mask;
        VALID = |REQ;
        IDX   = '0;
        // Descending scan so the lowest set position is the one that sticks.
        for (int j = 2*N_CH-1; j >= 0; j--) begin
            if (hit[j]) IDX = IW'(j % N_CH);
        end
    end

endmodule

// File: rtl/wrr_stream_arbiter.sv
// Merges N_CH FWFT FIFO streams into one ready/valid stream, round-robin with burst limit and packet hold.
// Latency: READ_GRANT same cycle as WRITE_REQ (register empty), OUT_VALID one cycle later.
// Backpressure: no pop while OUT_VALID & !OUT_READY; output word/channel held stable until taken.
// Ports:
//   CLK, RST_N           clock, asynchronous active-low reset
//   WRITE_REQ/HOLD_REQ   per-channel "word available" / "keep grant" (packet in progress)
//   DATA_IN              channel i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   READ_GRANT           one-hot pop strobe back to the source FIFO
//   OUT_READY/OUT_VALID/OUT_DATA/OUT_CH  registered output stage with source channel tag
module wrr_stream_arbiter
    import wrr_stream_arbiter_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [N_CH-1:0]            WRITE_REQ,
    input  logic [N_CH-1:0]            HOLD_REQ,
    input  logic [N_CH*DATA_WIDTH-1:0] DATA_IN,
    output logic [N_CH-1:0]            READ_GRANT,
    input  logic                       OUT_READY,
    output logic                       OUT_VALID,
    output logic [DATA_WIDTH-1:0]      OUT_DATA,
    output logic [clog2(N_CH)-1:0]     OUT_CH
);

    localparam int CW = clog2(N_CH);
    // With no burst limit the counter is never consulted; keep one bit.
    localparam int BW = (MAX_BURST == 0) ? 1 : clog2(MAX_BURST + 1);

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cur;
    logic [CW-1:0]         last_ch;
    logic [CW-1:0]         pick_idx;
    logic [CW-1:0]         gnt_idx;
    logic                  pick_vld;
    logic                  gnt;
    logic                  load_en;
    logic                  limit_hit;
    logic [BW-1:0]         burst_cnt;
    logic [DATA_WIDTH-1:0] ch_dat [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_dat[i] = DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .N_CH (N_CH)
    ) u_pick (
        .REQ   (WRITE_REQ),
        .LAST  (last_ch),
        .VALID (pick_vld),
        .IDX   (pick_idx)
    );

    // Output register can take a word when empty or being drained this cycle.
    assign load_en   = !OUT_VALID || OUT_READY;
    assign limit_hit = (MAX_BURST != 0) && (int'(burst_cnt) >= MAX_BURST);

    always_comb begin
        state_nxt  = state;
        gnt        = 1'b0;
        gnt_idx    = cur;
        READ_GRANT = '0;
        case (state)
            ST_IDLE: begin
                if (pick_vld && load_en) begin
                    gnt       = 1'b1;
                    gnt_idx   = pick_idx;
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                // HOLD_REQ lets a packet run past the burst limit.
                if (WRITE_REQ[cur] && load_en && (!limit_hit || HOLD_REQ[cur])) begin
                    gnt = 1'b1;
                end
                // A held channel keeps the lock even while it has no word.
                if (!HOLD_REQ[cur] && (!WRITE_REQ[cur] || limit_hit)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // The pop strobe is combinational; keep it quiet while reset is held
        // so sources are not drained into a register that is being cleared.
        if (!RST_N) gnt = 1'b0;
        if (gnt) READ_GRANT[gnt_idx] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            cur       <= '0;
            last_ch   <= CW'(N_CH - 1);
            burst_cnt <= '0;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_CH    <= '0;
        end else begin
            state <= state_nxt;

            if (gnt) begin
                OUT_VALID <= 1'b1;
                OUT_DATA  <= ch_dat[gnt_idx];
                OUT_CH    <= gnt_idx;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end

            if (state == ST_IDLE) begin
                if (gnt) begin
                    cur       <= pick_idx;
                    last_ch   <= pick_idx;
                    burst_cnt <= BW'(1);
                end
            end else if (state_nxt == ST_IDLE) begin
                burst_cnt <= '0;
            end else if (gnt && (burst_cnt != '1)) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

endmodule
